// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and helpers for the unified-RAM controller.
// States, access size codes and the byte-count decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [31:0] IO_BASE_DEF  = 32'h0003_0000;
  localparam int          IF_BYTES_DEF = 4;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller_byte_assembler.sv
// byte_assembler: little-endian merge of serial read bytes.
// merged shows the word with the current byte already inserted.
module byte_assembler (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  byteIn,
  output logic [31:0] merged
);

  logic [1:0]  idx;
  logic [31:0] acc;

  assign merged = acc | (32'(byteIn) << {idx, 3'b000});

  // Byte slot counter and accumulator, cleared at each new access
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (clear) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (capture) begin
      idx <= idx + 2'd1;
      acc <= merged;
    end
  end

endmodule

// File: rtl/mem_controller.sv
// mem_controller: IF/LSB arbiter and byte serializer for the unified RAM.
// Define MEM_CTRL_IO_STALL_EN to hold I/O writes while ioBufferFull is set.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
  parameter int          IF_BYTES = IF_BYTES_DEF
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        lsbFlag,
  input  logic [2:0]  lsbOp,
  input  logic [31:0] lsbAddr,
  input  logic [31:0] lsbDataIn,
  output logic [31:0] lsbDataOut,
  output logic        lsbOkFlag,
  input  logic        ifFlag,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifDataOut,
  output logic        ifOkFlag,
  input  logic [7:0]  memDin,
  output logic [7:0]  memDout,
  output logic [31:0] memA,
  output logic        memWr,
  input  logic        ioBufferFull
);

  state_t      state;
  state_t      stateNext;
  logic [2:0]  cnt;
  logic [2:0]  nBytes;
  logic        isLsb;
  logic        isStore;
  logic [31:0] wData;
  logic        accept;
  logic        selLsb;
  logic        capture;
  logic        lastByte;
  logic        ioStall;
  logic        advance;
  logic [31:0] merged;

`ifdef MEM_CTRL_IO_STALL_EN
  assign ioStall = (state == WRITE) && (memA >= IO_BASE) && ioBufferFull;
`else
  logic unusedIo;
  assign unusedIo = ^{ioBufferFull, IO_BASE};
  assign ioStall  = 1'b0;
`endif

  assign advance = readyIn && !ioStall;

  // State register
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) state <= IDLE;
    else          state <= stateNext;
  end

  // Arbitration, sequencing, write strobe and ok pulses
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    selLsb    = 1'b0;
    capture   = 1'b0;
    lastByte  = 1'b0;
    memWr     = 1'b0;
    lsbOkFlag = 1'b0;
    ifOkFlag  = 1'b0;
    unique case (state)
      IDLE: begin
        if (readyIn) begin
          if (lsbFlag) begin
            accept    = 1'b1;
            selLsb    = 1'b1;
            stateNext = lsbOp[2] ? WRITE : READ;
          end else if (ifFlag && !clearIn) begin
            accept    = 1'b1;
            stateNext = READ;
          end
        end
      end
      READ: begin
        if (readyIn) begin
          if (clearIn) begin
            stateNext = IDLE;
          end else begin
            capture  = (cnt != 3'd0);
            lastByte = (cnt == nBytes);
            if (lastByte) stateNext = DONE;
          end
        end
      end
      WRITE: begin
        memWr = advance;
        if (advance && cnt == nBytes - 3'd1) stateNext = DONE;
      end
      DONE: begin
        if (isStore || !(clearIn && readyIn)) begin
          lsbOkFlag = isLsb;
          ifOkFlag  = !isLsb;
        end
        if (readyIn) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Access context, address/data sequencing and result registers
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt        <= 3'd0;
      nBytes     <= 3'd0;
      isLsb      <= 1'b0;
      isStore    <= 1'b0;
      wData      <= 32'd0;
      memA       <= 32'd0;
      memDout    <= 8'd0;
      lsbDataOut <= 32'd0;
      ifDataOut  <= 32'd0;
    end else if (accept) begin
      cnt     <= 3'd0;
      isLsb   <= selLsb;
      isStore <= selLsb && lsbOp[2];
      nBytes  <= selLsb ? byte_count(lsbOp[1:0]) : 3'(IF_BYTES);
      memA    <= selLsb ? lsbAddr : ifAddr;
      if (selLsb && lsbOp[2]) begin
        wData   <= lsbDataIn;
        memDout <= lsbDataIn[7:0];
      end
    end else if (state == READ && readyIn && !clearIn) begin
      cnt <= cnt + 3'd1;
      if (cnt < nBytes - 3'd1) memA <= memA + 32'd1;
      if (lastByte) begin
        if (isLsb) lsbDataOut <= merged;
        else       ifDataOut  <= merged;
      end
    end else if (state == WRITE && advance) begin
      cnt     <= cnt + 3'd1;
      memA    <= memA + 32'd1;
      memDout <= wData[15:8];
      wData   <= {8'h00, wData[31:8]};
    end
  end

  byte_assembler uAsm (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .clear   (accept),
    .capture (capture),
    .byteIn  (memDin),
    .merged  (merged)
  );

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed cycle-accurate checks of mem_controller.
// Byte-wide RAM model with one-cycle read latency drives memDin.
module tb_mem_controller;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        readyIn;
  logic        clearIn;
  logic        lsbFlag;
  logic [2:0]  lsbOp;
  logic [31:0] lsbAddr;
  logic [31:0] lsbDataIn;
  logic [31:0] lsbDataOut;
  logic        lsbOkFlag;
  logic        ifFlag;
  logic [31:0] ifAddr;
  logic [31:0] ifDataOut;
  logic        ifOkFlag;
  logic [7:0]  memDin;
  logic [7:0]  memDout;
  logic [31:0] memA;
  logic        memWr;
  logic        ioBufferFull;

  logic [7:0]  ram [0:8191];
  logic        preload = 1'b0;
  logic [12:0] plAddr = 13'd0;
  logic [7:0]  plData = 8'd0;
  int          wrCount = 0;
  int          ifOkCnt = 0;
  int          nChk = 0;
  int          nErr = 0;
  int          w0;
  int          k0;

  mem_controller dut (
    .clockIn      (clockIn),
    .resetIn      (resetIn),
    .readyIn      (readyIn),
    .clearIn      (clearIn),
    .lsbFlag      (lsbFlag),
    .lsbOp        (lsbOp),
    .lsbAddr      (lsbAddr),
    .lsbDataIn    (lsbDataIn),
    .lsbDataOut   (lsbDataOut),
    .lsbOkFlag    (lsbOkFlag),
    .ifFlag       (ifFlag),
    .ifAddr       (ifAddr),
    .ifDataOut    (ifDataOut),
    .ifOkFlag     (ifOkFlag),
    .memDin       (memDin),
    .memDout      (memDout),
    .memA         (memA),
    .memWr        (memWr),
    .ioBufferFull (ioBufferFull)
  );

  always #5 clockIn = ~clockIn;

  always @(posedge clockIn) begin
    if (preload) ram[plAddr] <= plData;
    else if (memWr) ram[memA[12:0]] <= memDout;
    memDin <= ram[memA[12:0]];
    if (memWr) wrCount <= wrCount + 1;
    if (ifOkFlag) ifOkCnt <= ifOkCnt + 1;
  end

  task automatic cyc();
    @(posedge clockIn);
    #1;
  endtask

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    plAddr  = a;
    plData  = d;
    preload = 1'b1;
    cyc();
    preload = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    resetIn      = 1'b1;
    readyIn      = 1'b1;
    clearIn      = 1'b0;
    lsbFlag      = 1'b0;
    lsbOp        = 3'b000;
    lsbAddr      = 32'd0;
    lsbDataIn    = 32'd0;
    ifFlag       = 1'b0;
    ifAddr       = 32'd0;
    ioBufferFull = 1'b0;
    #1 resetIn = 1'b0;
    #2;
    chk("rst_memA", memA, 32'd0);
    chk("rst_memDout", 32'(memDout), 32'd0);
    chk("rst_memWr", 32'(memWr), 32'd0);
    chk("rst_oks", {30'd0, lsbOkFlag, ifOkFlag}, 32'd0);
    chk("rst_lsbData", lsbDataOut, 32'd0);
    chk("rst_ifData", ifDataOut, 32'd0);

    poke(13'h100, 8'h11);
    poke(13'h101, 8'h22);
    poke(13'h102, 8'h33);
    poke(13'h103, 8'h44);
    poke(13'h300, 8'hA5);
    poke(13'h1000, 8'h13);
    poke(13'h1001, 8'h05);
    poke(13'h1002, 8'h00);
    poke(13'h1003, 8'h00);
    poke(13'h1FFF, 8'h9A);
    poke(13'h0000, 8'hBC);
    resetIn = 1'b1;
    cyc();
    cyc();

    // LSB word load at 0x100
    cyc();
    lsbFlag = 1'b1; lsbOp = 3'b011; lsbAddr = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      cyc(); #1;
      chk("ld_memA", memA, 32'h100 + 32'(c - 1));
    end
    cyc(); #1;
    chk("ld_ok_c5", 32'(lsbOkFlag), 32'd0);
    cyc(); lsbFlag = 1'b0; #1;
    chk("ld_ok_c6", 32'(lsbOkFlag), 32'd1);
    chk("ld_data", lsbDataOut, 32'h4433_2211);
    cyc(); #1;
    chk("ld_ok_c7", 32'(lsbOkFlag), 32'd0);

    // LSB half store 0xBEEF to 0x202
    cyc();
    w0 = wrCount;
    lsbFlag = 1'b1; lsbOp = 3'b101; lsbAddr = 32'h202;
    lsbDataIn = 32'h0000_BEEF;
    cyc(); #1;
    chk("sh_wr_c1", 32'(memWr), 32'd1);
    chk("sh_memA_c1", memA, 32'h202);
    chk("sh_dout_c1", 32'(memDout), 32'hEF);
    cyc(); #1;
    chk("sh_wr_c2", 32'(memWr), 32'd1);
    chk("sh_memA_c2", memA, 32'h203);
    chk("sh_dout_c2", 32'(memDout), 32'hBE);
    cyc(); lsbFlag = 1'b0; #1;
    chk("sh_ok_c3", 32'(lsbOkFlag), 32'd1);
    chk("sh_wr_c3", 32'(memWr), 32'd0);
    cyc(); cyc();
    chk("sh_nwr", 32'(wrCount - w0), 32'd2);
    chk("sh_ram0", 32'(ram[13'h202]), 32'hEF);
    chk("sh_ram1", 32'(ram[13'h203]), 32'hBE);

    // Simultaneous LSB byte load and IF fetch
    cyc();
    k0 = ifOkCnt;
    lsbFlag = 1'b1; lsbOp = 3'b000; lsbAddr = 32'h300;
    ifFlag = 1'b1; ifAddr = 32'h1000;
    cyc(); #1;
    chk("arb_memA", memA, 32'h300);
    cyc();
    cyc(); lsbFlag = 1'b0; #1;
    chk("arb_lsbOk", 32'(lsbOkFlag), 32'd1);
    chk("arb_ifOk_c3", 32'(ifOkFlag), 32'd0);
    chk("arb_lsbData", lsbDataOut, 32'h0000_00A5);
    cyc(); #1;
    chk("arb_ifOk_c4", 32'(ifOkFlag), 32'd0);
    cyc(); #1;
    chk("arb_if_memA", memA, 32'h1000);
    cyc(); cyc(); cyc();
    cyc(); #1;
    chk("arb_ifOk_c9", 32'(ifOkFlag), 32'd0);
    cyc(); ifFlag = 1'b0; #1;
    chk("arb_ifOk_c10", 32'(ifOkFlag), 32'd1);
    chk("arb_lsbOk_c10", 32'(lsbOkFlag), 32'd0);
    chk("arb_ifData", ifDataOut, 32'h0000_0513);
    cyc(); cyc();
    chk("arb_ifOkCnt", 32'(ifOkCnt - k0), 32'd1);

    // IF fetch flushed mid-read, then a word store flushed mid-write
    cyc();
    k0 = ifOkCnt;
    ifFlag = 1'b1; ifAddr = 32'h1000;
    cyc(); cyc();
    cyc(); clearIn = 1'b1; ifFlag = 1'b0; #1;
    chk("fl_ifOk_c3", 32'(ifOkFlag), 32'd0);
    cyc(); clearIn = 1'b0;
    w0 = wrCount;
    lsbFlag = 1'b1; lsbOp = 3'b111; lsbAddr = 32'h400;
    lsbDataIn = 32'hCAFE_F00D;
    cyc(); #1;
    chk("fl_st_wr_c5", 32'(memWr), 32'd1);
    chk("fl_st_memA_c5", memA, 32'h400);
    cyc(); clearIn = 1'b1; #1;
    chk("fl_st_wr_c6", 32'(memWr), 32'd1);
    cyc(); clearIn = 1'b0;
    cyc();
    cyc(); lsbFlag = 1'b0; #1;
    chk("fl_st_ok_c9", 32'(lsbOkFlag), 32'd1);
    cyc(); cyc();
    chk("fl_st_nwr", 32'(wrCount - w0), 32'd4);
    chk("fl_st_ram", {ram[13'h403], ram[13'h402], ram[13'h401], ram[13'h400]},
        32'hCAFE_F00D);
    chk("fl_ifOkCnt", 32'(ifOkCnt - k0), 32'd0);

    // Word store with a 3-cycle ready stall, then a stretched ok
    cyc();
    w0 = wrCount;
    lsbFlag = 1'b1; lsbOp = 3'b111; lsbAddr = 32'h500;
    lsbDataIn = 32'h1234_5678;
    cyc(); cyc();
    cyc(); readyIn = 1'b0; #1;
    chk("rdy_wr_c3", 32'(memWr), 32'd0);
    cyc();
    cyc(); #1;
    chk("rdy_wr_c5", 32'(memWr), 32'd0);
    cyc(); readyIn = 1'b1; #1;
    chk("rdy_wr_c6", 32'(memWr), 32'd1);
    chk("rdy_memA_c6", memA, 32'h502);
    cyc(); #1;
    chk("rdy_ok_c7", 32'(lsbOkFlag), 32'd0);
    cyc(); readyIn = 1'b0; lsbFlag = 1'b0; #1;
    chk("rdy_ok_c8", 32'(lsbOkFlag), 32'd1);
    cyc(); readyIn = 1'b1; #1;
    chk("rdy_ok_c9", 32'(lsbOkFlag), 32'd1);
    cyc(); #1;
    chk("rdy_ok_c10", 32'(lsbOkFlag), 32'd0);
    chk("rdy_nwr", 32'(wrCount - w0), 32'd4);
    chk("rdy_ram", {ram[13'h503], ram[13'h502], ram[13'h501], ram[13'h500]},
        32'h1234_5678);

    // Half load straddling the top of the address space
    cyc();
    lsbFlag = 1'b1; lsbOp = 3'b001; lsbAddr = 32'hFFFF_FFFF;
    cyc(); #1;
    chk("wrap_memA_c1", memA, 32'hFFFF_FFFF);
    cyc(); #1;
    chk("wrap_memA_c2", memA, 32'h0000_0000);
    cyc();
    cyc(); lsbFlag = 1'b0; #1;
    chk("wrap_ok_c4", 32'(lsbOkFlag), 32'd1);
    chk("wrap_data", lsbDataOut, 32'h0000_BC9A);

`ifdef MEM_CTRL_IO_STALL_EN
    // Byte store to I/O space held back by a full UART buffer
    cyc();
    w0 = wrCount;
    ioBufferFull = 1'b1;
    lsbFlag = 1'b1; lsbOp = 3'b100; lsbAddr = 32'h0003_0000;
    lsbDataIn = 32'h0000_0041;
    cyc(); #1;
    chk("io_wr_c1", 32'(memWr), 32'd0);
    cyc(); cyc(); cyc();
    cyc(); #1;
    chk("io_wr_c5", 32'(memWr), 32'd0);
    cyc(); ioBufferFull = 1'b0; #1;
    chk("io_wr_c6", 32'(memWr), 32'd1);
    chk("io_dout_c6", 32'(memDout), 32'h41);
    cyc(); lsbFlag = 1'b0; #1;
    chk("io_ok_c7", 32'(lsbOkFlag), 32'd1);
    cyc(); cyc();
    chk("io_nwr", 32'(wrCount - w0), 32'd1);
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Sits between the byte-wide unified RAM and its two requesters: the instruction fetch unit (IF) and the load/store buffer (LSB).
- Arbitrates the two, serializes 1/2/4-byte accesses into byte transfers, assembles read bytes little-endian, and returns one `okFlag` pulse per completed access.
- LSB requests are level-held and masked by the LSB itself during the ok cycle; IF uses the same protocol.

Parameters:
- `IO_BASE`, 32'h0003_0000, first address treated as memory-mapped I/O (used only by the optional feature).
- `IF_BYTES`, 4, bytes per instruction fetch (fixed word).

Ports:
- `clockIn` in 1: clock.
- `resetIn` in 1: asynchronous, active-low reset.
- `readyIn` in 1: global ready; low freezes the block.
- `clearIn` in 1: branch-mispredict flush.
- `lsbFlag` in 1: LSB request (level).
- `lsbOp` in 3: {store, size[1:0]}; size 00=byte, 01=half, 11=word.
- `lsbAddr` in 32: LSB byte address.
- `lsbDataIn` in 32: store data, low bytes used.
- `lsbDataOut` out 32: raw read data, zero-extended (LSB sign-extends).
- `lsbOkFlag` out 1: LSB access complete, 1-cycle pulse.
- `ifFlag` in 1: fetch request (level).
- `ifAddr` in 32: fetch address.
- `ifDataOut` out 32: fetched word.
- `ifOkFlag` out 1: fetch complete, 1-cycle pulse.
- `memDin` in 8: RAM read byte.
- `memDout` out 8: RAM write byte.
- `memA` out 32: RAM byte address.
- `memWr` out 1: 1=write, 0=read.
- `ioBufferFull` in 1: UART buffer full.

Behaviour:
- Reset (async, `resetIn`=0):
  - state=IDLE, byte counter=0.
  - `memA`=0, `memDout`=0, `memWr`=0.
  - `lsbOkFlag`=`ifOkFlag`=0, `lsbDataOut`=`ifDataOut`=0.
- States:
  - IDLE: accept a request.
  - READ: issue addresses, capture bytes.
  - WRITE: drive bytes.
  - DONE: 1 cycle, pulse ok, return to IDLE.
- Byte count N:
  - byte=1, half=2, word=4.
  - Fetch is always `IF_BYTES`.
- Arbitration (IDLE only):
  - LSB has priority over IF.
  - No preemption once an access starts.
  - A request whose ok pulse is high this cycle is ignored.
  - `clearIn` in IDLE blocks acceptance of an IF request that cycle.
- Timing, request sampled at edge E0:
  - Read: `memA` = addr+k during cycle k+1, for k=0..N-1. RAM returns the byte one cycle later. Byte k is placed in bits [8k+7:8k]. Ok pulses in cycle N+2; word access = cycle 6.
  - Write: `memA` = addr+k, `memDout` = data[8k+7:8k], `memWr`=1 during cycle k+1. Ok pulses in cycle N+1; word access = cycle 5.
  - `memWr` is 0 outside WRITE.
  - Address increments are 32-bit and wrap modulo 2^32.
- Data outputs:
  - Registered; valid in the ok cycle; held until the next completion.
  - Unused upper bytes of `lsbDataOut` are 0.
- `clearIn` (with `readyIn`=1):
  - In-flight READ (IF or LSB load) aborts: no ok pulse, IDLE next cycle, `memWr` stays 0.
  - In-flight WRITE always completes, because a store is already committed.
  - A DONE for a read is suppressed if `clearIn` is high that cycle.
- `readyIn`=0:
  - State, counter, and registered outputs hold.
  - `memWr` output gated to 0 so no duplicate write.
  - An ok pulse stretches until the first ready cycle.
- Outputs never assert `lsbOkFlag` and `ifOkFlag` in the same cycle.

Optional Feature:
- Macro: `MEM_CTRL_IO_STALL_EN`.
- When defined:
  - A WRITE byte whose address is at or above `IO_BASE` is not driven while `ioBufferFull`=1.
  - The state holds with `memWr`=0 until full drops, then proceeds.
  - Completion latency extends by the stall cycles.
- When undefined: `ioBufferFull` is ignored and timing is exactly as above.

Decomposition:
- Package `mem_ctrl_pkg`:
  - state enum {IDLE, READ, WRITE, DONE}.
  - Size codes (`SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b11).
  - `byte_count(size)` function.
  - `IO_BASE` default.
- Natural sub-module: `byte_assembler`, a counter plus little-endian byte shift/merge register with a clear.

Test Plan:
- LSB word load at 0x100, RAM holds bytes 11 22 33 44 -> `memA` 0x100..0x103 in cycles 1..4; `lsbOkFlag` in cycle 6 with `lsbDataOut`=0x44332211.
- LSB half store 0xBEEF to 0x202 -> writes EF@0x202 (cycle 1) and BE@0x203 (cycle 2); `lsbOkFlag` in cycle 3; exactly two `memWr` cycles.
- IF and LSB byte load requested in the same cycle -> LSB served first (ok in cycle 3); IF accepted next, `ifOkFlag` 6 cycles after its acceptance.
- IF fetch at 0x1000 with `clearIn` pulsed in cycle 3 -> no `ifOkFlag`, IDLE in cycle 4; a word store in flight under `clearIn` still completes all 4 writes.
- `readyIn` low for 3 cycles mid word store -> `memWr`=0 during stall; each of the 4 bytes is written exactly once; ok delayed by 3 cycles.
- With `MEM_CTRL_IO_STALL_EN`, byte store 0x41 to 0x30000 while `ioBufferFull`=1 for 5 cycles -> no write until full drops; then one write and ok next cycle.
